// File: rtl/fp_align.sv
// rtl/fp_align.sv - floating-point operand exponent compare and sticky mantissa alignment
module fp_align #(
    parameter int MAX_SHIFT = 27
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_a,
    input  logic        sign_b,
    input  logic [7:0]  exp_a,
    input  logic [7:0]  exp_b,
    input  logic [27:0] ext_mantis_a,
    input  logic [27:0] ext_mantis_b,
    input  logic [2:0]  type_a,
    input  logic [2:0]  type_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign_big,
    output logic        out_sign_small,
    output logic [7:0]  out_exp,
    output logic [27:0] out_mant_big,
    output logic [27:0] out_mant_small,
    output logic        out_swap,
    output logic        out_special
);

    typedef enum logic [1:0] {IDLE, COMPARE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic        a_sign_q, a_sign_d, b_sign_q, b_sign_d;
    logic [7:0]  a_exp_q, a_exp_d, b_exp_q, b_exp_d;
    logic [27:0] a_mant_q, a_mant_d, b_mant_q, b_mant_d;
    logic [2:0]  a_type_q, a_type_d, b_type_q, b_type_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [27:0] small_q, small_d;
    logic        o_sign_big_q, o_sign_big_d, o_sign_small_q, o_sign_small_d;
    logic [7:0]  o_exp_q, o_exp_d;
    logic [27:0] o_mant_big_q, o_mant_big_d, o_mant_small_q, o_mant_small_d;
    logic        o_swap_q, o_swap_d, o_special_q, o_special_d;

    logic [7:0]  eff_a, eff_b, diff;
    logic        swap, special;
    logic [4:0]  n;
    logic [27:0] shifted;

    // Latched operands stay stable through COMPARE/SHIFT, so these are valid there.
    always_comb begin
        eff_a   = (a_type_q == 3'd1) ? 8'd1 : a_exp_q;
        eff_b   = (b_type_q == 3'd1) ? 8'd1 : b_exp_q;
        special = !((a_type_q == 3'd1) || (a_type_q == 3'd2)) ||
                  !((b_type_q == 3'd1) || (b_type_q == 3'd2));
        swap    = eff_b > eff_a;
        diff    = swap ? (eff_b - eff_a) : (eff_a - eff_b);
        n       = (diff > 8'(MAX_SHIFT)) ? 5'(MAX_SHIFT) : diff[4:0];
        shifted = {1'b0, small_q[27:2], small_q[1] | small_q[0]};
    end

    always_comb begin
        state_d        = state_q;
        a_sign_d       = a_sign_q;
        b_sign_d       = b_sign_q;
        a_exp_d        = a_exp_q;
        b_exp_d        = b_exp_q;
        a_mant_d       = a_mant_q;
        b_mant_d       = b_mant_q;
        a_type_d       = a_type_q;
        b_type_d       = b_type_q;
        cnt_d          = cnt_q;
        small_d        = small_q;
        o_sign_big_d   = o_sign_big_q;
        o_sign_small_d = o_sign_small_q;
        o_exp_d        = o_exp_q;
        o_mant_big_d   = o_mant_big_q;
        o_mant_small_d = o_mant_small_q;
        o_swap_d       = o_swap_q;
        o_special_d    = o_special_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sign_d = sign_a;
                    b_sign_d = sign_b;
                    a_exp_d  = exp_a;
                    b_exp_d  = exp_b;
                    a_mant_d = ext_mantis_a;
                    b_mant_d = ext_mantis_b;
                    a_type_d = type_a;
                    b_type_d = type_b;
                    state_d  = COMPARE;
                end
            end
            COMPARE: begin
                if (special) begin
                    o_sign_big_d   = a_sign_q;
                    o_sign_small_d = b_sign_q;
                    o_exp_d        = a_exp_q;
                    o_mant_big_d   = a_mant_q;
                    o_mant_small_d = b_mant_q;
                    o_swap_d       = 1'b0;
                    o_special_d    = 1'b1;
                    state_d        = DONE;
                end else begin
                    small_d = swap ? a_mant_q : b_mant_q;
                    cnt_d   = n;
                    state_d = (n == 5'd0) ? DONE : SHIFT;
                    if (n == 5'd0) begin
                        o_sign_big_d   = a_sign_q;
                        o_sign_small_d = b_sign_q;
                        o_exp_d        = eff_a;
                        o_mant_big_d   = a_mant_q;
                        o_mant_small_d = b_mant_q;
                        o_swap_d       = 1'b0;
                        o_special_d    = 1'b0;
                    end
                end
            end
            SHIFT: begin
                small_d = shifted;
                cnt_d   = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    o_sign_big_d   = swap ? b_sign_q : a_sign_q;
                    o_sign_small_d = swap ? a_sign_q : b_sign_q;
                    o_exp_d        = swap ? eff_b : eff_a;
                    o_mant_big_d   = swap ? b_mant_q : a_mant_q;
                    o_mant_small_d = shifted;
                    o_swap_d       = swap;
                    o_special_d    = 1'b0;
                    state_d        = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            a_sign_q       <= 1'b0;
            b_sign_q       <= 1'b0;
            a_exp_q        <= 8'd0;
            b_exp_q        <= 8'd0;
            a_mant_q       <= 28'd0;
            b_mant_q       <= 28'd0;
            a_type_q       <= 3'd0;
            b_type_q       <= 3'd0;
            cnt_q          <= 5'd0;
            small_q        <= 28'd0;
            o_sign_big_q   <= 1'b0;
            o_sign_small_q <= 1'b0;
            o_exp_q        <= 8'd0;
            o_mant_big_q   <= 28'd0;
            o_mant_small_q <= 28'd0;
            o_swap_q       <= 1'b0;
            o_special_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            a_sign_q       <= a_sign_d;
            b_sign_q       <= b_sign_d;
            a_exp_q        <= a_exp_d;
            b_exp_q        <= b_exp_d;
            a_mant_q       <= a_mant_d;
            b_mant_q       <= b_mant_d;
            a_type_q       <= a_type_d;
            b_type_q       <= b_type_d;
            cnt_q          <= cnt_d;
            small_q        <= small_d;
            o_sign_big_q   <= o_sign_big_d;
            o_sign_small_q <= o_sign_small_d;
            o_exp_q        <= o_exp_d;
            o_mant_big_q   <= o_mant_big_d;
            o_mant_small_q <= o_mant_small_d;
            o_swap_q       <= o_swap_d;
            o_special_q    <= o_special_d;
        end
    end

    assign in_ready       = (state_q == IDLE);
    assign out_valid      = (state_q == DONE);
    assign out_sign_big   = o_sign_big_q;
    assign out_sign_small = o_sign_small_q;
    assign out_exp        = o_exp_q;
    assign out_mant_big   = o_mant_big_q;
    assign out_mant_small = o_mant_small_q;
    assign out_swap       = o_swap_q;
    assign out_special    = o_special_q;

endmodule

// File: doc/fp_align.md
FP_ALIGN -- requirements
Module: fp_align

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, listed first: clk input 1 (all state on rising edge); rst_n input 1 (async active-low reset).
REQ-002 MAX_SHIFT, default 27, SHALL be the shift-count clamp; legal range 1..27.
REQ-003 in_valid  input  1  operand pair present.
REQ-004 in_ready  output 1  block can accept; high only in IDLE.
REQ-005 sign_a / sign_b  input  1  operand signs.
REQ-006 exp_a / exp_b  input  8  biased exponents.
REQ-007 ext_mantis_a / ext_mantis_b  input  28  extended mantissas: [27]=0 carry guard, [26]=hidden bit, [25:3]=fraction, [2:0]=guard/round/sticky.
REQ-008 type_a / type_b  input  3  0=zero, 1=denormal, 2=normal, 3=infinity, 4=NaN; 5..7 treated as NaN.
REQ-009 out_valid  output 1  aligned result present.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out_sign_big / out_sign_small  output 1  signs of larger-exponent / smaller-exponent operand.
REQ-012 out_exp  output 8  common (larger) effective exponent.
REQ-013 out_mant_big / out_mant_small  output 28  unshifted big mantissa / right-aligned small mantissa.
REQ-014 out_swap  output 1  1 when operand B is the big operand.
REQ-015 out_special  output 1  either operand is zero, infinity or NaN; no alignment performed.

Function
REQ-016 FSM states SHALL be IDLE, COMPARE, SHIFT, DONE.
REQ-017 IDLE: in_valid&&in_ready at an edge SHALL latch all operand inputs and go to COMPARE.
REQ-018 Effective exponent SHALL be 1 for denormal operands, exp otherwise.
REQ-019 COMPARE: if effB>effA, B is big (swap=1); ties and effA>effB keep A big (swap=0).
REQ-020 COMPARE: shift count n = min(|effA-effB|, MAX_SHIFT); next state SHIFT if n>0, else DONE.
REQ-021 COMPARE with any special operand type SHALL go directly to DONE with out_special=1, out_mant_big=ext_mantis_a, out_mant_small=ext_mantis_b, out_exp=exp_a, swap=0, signs a/b.
REQ-022 SHIFT: each cycle SHALL shift the small mantissa right one bit, new bit0 = old bit1 | old bit0 (sticky), decrement n; go to DONE when n reaches 0.
REQ-023 Latency: out_valid SHALL rise after edge E0+n+1, E0 = acceptance edge (special: E0+1).
REQ-024 DONE: out_valid=1, all out_* stable until out_valid&&out_ready edge, then IDLE.
REQ-025 No new operand SHALL be accepted in the cycle a result is consumed; in_ready rises the following cycle.
REQ-026 out_* other than out_valid are don't-care outside DONE but SHALL hold their last value.
REQ-027 n clamped at MAX_SHIFT SHALL yield small mantissa {27'b0, |original} for MAX_SHIFT=27.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, out_valid=0, all other outputs 0, in_ready=1, regardless of state (including mid-SHIFT).
REQ-029 After rst_n deasserts, the first accept SHALL behave identically to a post-power-up accept; no partial result emitted.

Verification
REQ-030 Equal exponents: A exp=127 mant=0x4000000, B exp=127 mant=0x6000000, normal -> out_valid after E0+1, out_exp=127, big=0x4000000, small=0x6000000, swap=0.
REQ-031 Diff 3: A exp=127 mant=0x4000000, B exp=130 mant=0x4000000 -> out_valid after E0+4, swap=1, out_exp=130, small=0x0800000, big=0x4000000.
REQ-032 Clamp: A exp=10 mant=0x4000003, B exp=50 -> n=27, out_valid after E0+28, small=0x0000001, out_exp=50.
REQ-033 Special: type_b=4 -> out_valid after E0+1, out_special=1, mantissas passed unshifted, no SHIFT state entered.
REQ-034 Backpressure: out_ready low 5 cycles in DONE -> outputs stable, in_ready=0; out_ready high -> IDLE next edge, in_ready=1.
REQ-035 Reset mid-SHIFT: rst_n low at SHIFT cycle 2 of 10 -> outputs 0 and in_ready=1 without waiting for clk; subsequent transaction correct.
